// File: rtl/mptw_fetch_stage.sv
// MPT walker fetch stage: in-order request queue with speculative tagging.
// Optional zero-latency bypass when MPTW_FETCH_BYPASS_EN is defined.
package mptw_pkg;
  typedef enum logic [1:0] {
    MPT_FLUSH_NONE = 2'd0,
    MPT_FLUSH_SPEC = 2'd1,
    MPT_FLUSH_ALL  = 2'd2
  } mptw_flush_ctrl_e;
endpackage

module mptw_fetch_stage
  import mptw_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [ID_WIDTH-1:0]      req_id_i,
  input  logic [1:0]               req_access_i,
  input  logic                     req_spec_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [ADDR_WIDTH-1:0]    out_addr_o,
  output logic [ID_WIDTH-1:0]      out_id_o,
  output logic [1:0]               out_access_o,
  output logic                     out_spec_o,
  input  mptw_flush_ctrl_e         ctrl_flush_i,
  input  logic                     ctrl_stall_i,
  input  logic                     commit_spec_i,
  output logic                     status_busy_o,
  output logic [$clog2(DEPTH):0]   status_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [ID_WIDTH-1:0]   id;
    logic [1:0]            access;
  } pay_t;

  logic [PW:0]      head_q, tail_q;
  logic [DEPTH-1:0] occ_q, live_q, spec_q;
  pay_t             pay_q [DEPTH];

  logic [PW-1:0] hidx, tidx;
  logic h_occ, h_live;
  logic full, flush_none;
  logic q_valid, byp, push, pop, bubble;
  logic [CW-1:0] cnt;

  assign hidx       = head_q[PW-1:0];
  assign tidx       = tail_q[PW-1:0];
  assign h_occ      = occ_q[hidx];
  assign h_live     = live_q[hidx];
  assign flush_none = (ctrl_flush_i == MPT_FLUSH_NONE);
  assign full       = (hidx == tidx) && (head_q[PW] != tail_q[PW]);

  // Ready depends on registered state only, so a pop never opens it early
  assign req_ready_o = rst_ni && !full && !ctrl_stall_i && flush_none;
  assign q_valid = rst_ni && h_occ && h_live && !ctrl_stall_i && flush_none;

`ifdef MPTW_FETCH_BYPASS_EN
  assign byp = rst_ni && !(|occ_q) && !ctrl_stall_i && flush_none
               && req_valid_i;
`else
  assign byp = 1'b0;
`endif

  assign push   = req_valid_i && req_ready_o && !(byp && out_ready_i);
  assign pop    = q_valid && out_ready_i;
  assign bubble = rst_ni && h_occ && !h_live && flush_none;

  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt = cnt + {{(CW-1){1'b0}}, occ_q[i] & live_q[i]};
  end

  always_comb begin
    out_valid_o    = q_valid;
    out_addr_o     = '0;
    out_id_o       = '0;
    out_access_o   = '0;
    out_spec_o     = 1'b0;
    status_busy_o  = rst_ni && (|occ_q);
    status_count_o = rst_ni ? cnt : '0;
    if (rst_ni && h_occ) begin
      out_addr_o   = pay_q[hidx].addr;
      out_id_o     = pay_q[hidx].id;
      out_access_o = pay_q[hidx].access;
      out_spec_o   = spec_q[hidx];
    end
    if (byp) begin
      out_valid_o  = 1'b1;
      out_addr_o   = req_addr_i;
      out_id_o     = req_id_i;
      out_access_o = req_access_i;
      out_spec_o   = req_spec_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      live_q <= '0;
      spec_q <= '0;
      for (int i = 0; i < DEPTH; i++) pay_q[i] <= '0;
    end else if (ctrl_flush_i == MPT_FLUSH_ALL) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      live_q <= '0;
      spec_q <= '0;
    end else if (ctrl_flush_i == MPT_FLUSH_SPEC) begin
      live_q <= live_q & ~spec_q;
    end else begin
      if (commit_spec_i) spec_q <= spec_q & ~occ_q;
      if (push) begin
        occ_q[tidx]  <= 1'b1;
        live_q[tidx] <= 1'b1;
        spec_q[tidx] <= req_spec_i;
        pay_q[tidx]  <= '{addr: req_addr_i, id: req_id_i,
                           access: req_access_i};
        tail_q       <= tail_q + 1'b1;
      end
      if (pop || bubble) begin
        occ_q[hidx] <= 1'b0;
        head_q      <= head_q + 1'b1;
      end
    end
  end

endmodule

// File: doc/mptw_fetch_stage.md
# mptw_fetch_stage

Fetch stage of the MPT walker pipeline: first stage behind the system request interface, feeding the issue stage. Buffers incoming protection-check requests in an in-order queue of DEPTH slots and tags each with a speculative flag. Obeys the flush and stall controls driven by the walker control unit and reports occupancy back on its status bus.

## Interface
- Parameters:
  - `DEPTH`, default 4: queue slots; a power of two, at least 2.
  - `ADDR_WIDTH`, default 64: request address width.
  - `ID_WIDTH`, default 4: transaction ID width.
- Ports:
  - `clk_i` in 1: the block's only clock.
  - `rst_ni` in 1: reset, synchronous and active-low.
  - `req_valid_i` in 1 / `req_ready_o` out 1: upstream handshake.
  - `req_addr_i` in ADDR_WIDTH, `req_id_i` in ID_WIDTH, `req_access_i` in 2, `req_spec_i` in 1: request payload.
  - `out_valid_o` out 1 / `out_ready_i` in 1: handshake to the issue stage.
  - `out_addr_o` out ADDR_WIDTH, `out_id_o` out ID_WIDTH, `out_access_o` out 2, `out_spec_o` out 1: head payload.
  - `ctrl_flush_i` in `$bits(mptw_flush_ctrl_e)`: MPT_FLUSH_NONE, MPT_FLUSH_SPEC or MPT_FLUSH_ALL.
  - `ctrl_stall_i` in 1: stall from the control unit.
  - `commit_spec_i` in 1: the speculation resolved as correct.
  - `status_busy_o` out 1: at least one slot is occupied.
  - `status_count_o` out $clog2(DEPTH)+1: number of live requests.

## Operation
- Circular queue with head and tail pointers.
- Each slot holds an `occ` bit (slot in use), a `live` bit (request still valid) and the request payload.
- Push:
  - Condition: `req_valid_i && req_ready_o`.
  - Writes the tail slot with `occ=1`, `live=1` and the payload. Tail advances, wrapping DEPTH-1 to 0.
- Ready rule: `req_ready_o = !full && !ctrl_stall_i && ctrl_flush_i==MPT_FLUSH_NONE`. Full means all DEPTH slots have `occ` set.
- Pop:
  - Condition: the head slot has `occ && live`, there is no stall, there is no flush, and `out_ready_i` is high.
  - Clears `occ` at the head. Head advances.
- Bubble drain:
  - Condition: the head slot has `occ && !live` and `ctrl_flush_i==NONE`.
  - Clears `occ` at the head and advances the head. No handshake. Happens even during a stall.
  - At most one bubble drains per cycle.
- MPT_FLUSH_ALL: clears every `occ` and `live` bit and resets both pointers to 0 at the next edge. Any push or pop in that cycle is suppressed.
- MPT_FLUSH_SPEC:
  - Clears `live` on every slot whose spec bit is set. Those slots become bubbles.
  - Pointers are unchanged. Push and pop are suppressed that cycle.
- `commit_spec_i`:
  - Clears the spec bit of every resident occupied slot.
  - A request pushed in the same cycle keeps its own `req_spec_i`.
  - If MPT_FLUSH_SPEC is asserted in the same cycle, the flush wins and the commit is ignored.
- Priority: reset > FLUSH_ALL > FLUSH_SPEC > stall > normal operation.
- `status_count_o` counts slots with `occ && live`. `status_busy_o` is the OR of all `occ` bits, so bubbles count as busy.
- Payload outputs always show the head slot contents, and are 0 when that slot is unoccupied.

## Timing
- Reset:
  - Pointers, `occ`, `live` and spec bits are all cleared.
  - `req_ready_o=0` while `rst_ni` is low. `out_valid_o=0`.
  - All payload outputs, `status_busy_o` and `status_count_o` are 0.
  - The first cycle after release has `req_ready_o=1`.
- A reset asserted mid-operation discards all contents at the next edge.
- `out_valid_o = head.occ && head.live && !ctrl_stall_i && ctrl_flush_i==NONE`. This is combinational from state and controls.
- Latency: a pushed request is visible on `out_*` in the cycle after the push edge, when the queue was otherwise empty of live entries and no bubbles were ahead of it.
- Throughput: one push and one pop in the same cycle when the queue is neither empty nor full. When full, a same-cycle pop does not open `req_ready_o`; ready is computed from registered state only.
- Wrap-around: pointers carry a wrap bit. Full is `head==tail` with the wrap bits differing. Empty is `head==tail` with the wrap bits equal.
- Once asserted, `out_valid_o` with a given payload holds until it is popped, or until it is withdrawn by a stall, a flush or a reset.

## Configuration
- `MPTW_FETCH_BYPASS_EN`:
  - Defined: when the queue has no occupied slot, there is no stall or flush, and `req_valid_i` is high, the request appears combinationally on `out_*` with `out_valid_o=1` in the same cycle. If `out_ready_i` is high, it is consumed without being written into the queue (zero-cycle latency).
  - Undefined: every request passes through a slot, giving a minimum latency of one cycle.

## Test plan
- Reset, then push IDs 1,2,3 with `out_ready_i=0` -> `status_count_o=3`. Raise `out_ready_i` -> IDs pop in order 1,2,3 on consecutive cycles.
- DEPTH=4: push 4 requests -> `req_ready_o=0`. Pop 1 -> `req_ready_o=1` the next cycle. Keep pushing and popping for 10 requests through a pointer wrap -> order preserved, no loss.
- Queue holds ID 1 non-spec, ID 2 spec, ID 3 non-spec. Pulse MPT_FLUSH_SPEC -> `status_count_o` goes 3 to 2. Pops deliver 1 then 3, with ID 2 drained as a bubble in one extra cycle.
- Queue holds 3 entries, stall high plus a push in the same cycle -> push refused, `out_valid_o=0`. Pulse FLUSH_ALL during the stall -> next cycle `status_busy_o=0`, `status_count_o=0`.
- Queue holds spec ID 5; `commit_spec_i` and MPT_FLUSH_SPEC in the same cycle -> ID 5 is discarded. Repeat with `commit_spec_i` alone -> ID 5 emerges with `out_spec_o=0`.
- With `MPTW_FETCH_BYPASS_EN`, empty queue, `out_ready_i=1`, push ID 7 -> `out_valid_o=1` and `out_id_o=7` in the same cycle, and `status_busy_o` stays 0.
